// File: rtl/keypad_pkg.sv
// Shared keypad definitions: key-code width helper, the 4x4 calculator
// keymap (scan index -> hex digit) and the event record carried by the FIFO.
package keypad_pkg;

  // Widest key code any legal geometry needs (8x8 = 64 keys)
  localparam int MAX_CODE_W = 6;

  typedef struct packed {
    logic [MAX_CODE_W-1:0] code;
    logic                  press;
  } key_evt_t;

  function automatic int key_code_w(input int rows, input int cols);
    return (rows * cols > 2) ? $clog2(rows * cols) : 1;
  endfunction

  // Index 0 is the LSB nibble: 0..15 -> D,C,B,A,F,9,6,3,0,8,5,2,E,7,4,1
  localparam logic [15:0][3:0] CALC_KEYMAP = {
    4'h1, 4'h4, 4'h7, 4'hE, 4'h2, 4'h5, 4'h8, 4'h0,
    4'h3, 4'h6, 4'h9, 4'hF, 4'hA, 4'hB, 4'hC, 4'hD
  };

endpackage

// File: rtl/keypad_evt_fifo.sv
// Show-ahead synchronous FIFO for key events.
// Ports: clk/rst (async high), i_push/i_din write side, i_pop read side,
// o_dout = head entry, o_full/o_empty flags, o_count = occupancy.
// A push while full is accepted only if a pop happens in the same cycle.
module keypad_evt_fifo #(
  parameter int W     = 7,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_push,
  input  logic [W-1:0]               i_din,
  input  logic                       i_pop,
  output logic [W-1:0]               o_dout,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_count
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [AW:0]   r_cnt;
  logic          w_pop, w_push;

  assign w_pop  = i_pop && (r_cnt != '0);
  assign w_push = i_push && ((r_cnt != (AW+1)'(DEPTH)) || w_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop)  r_rp <= r_rp + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Storage needs no reset; the top masks the head while empty
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp] <= i_din;
  end

  assign o_dout  = r_mem[r_rp];
  assign o_full  = (r_cnt == (AW+1)'(DEPTH));
  assign o_empty = (r_cnt == '0);
  assign o_count = r_cnt;

endmodule

// File: rtl/keypad_scan_ctrl.sv
// ROWS x COLS matrix keypad scanner.
// Ports: clk, rst (async high); row (raw, active-low) in, col (one-hot
// active-low) out; evt_valid/evt_ready/evt_code/evt_press event stream;
// key_state debounced map; multi_key; overflow sticky with ovf_clr.
// Columns are driven in turn, rows are sampled through a 2-flop synchroniser
// at the end of each column dwell, and a full frame is debounced before its
// difference against key_state is emitted one event per cycle into a FIFO.
module keypad_scan_ctrl
  import keypad_pkg::*;
#(
  parameter  int ROWS       = 4,
  parameter  int COLS       = 4,
  parameter  int SCAN_DIV   = 999999,
  parameter  int DEBOUNCE   = 3,
  parameter  int FIFO_DEPTH = 4,
  localparam int CODE_W     = key_code_w(ROWS, COLS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [ROWS-1:0]        row,
  output logic [COLS-1:0]        col,
  output logic                   evt_valid,
  input  logic                   evt_ready,
  output logic [CODE_W-1:0]      evt_code,
  output logic                   evt_press,
  output logic [ROWS*COLS-1:0]   key_state,
  output logic                   multi_key,
  output logic                   overflow,
  input  logic                   ovf_clr
);
  localparam int N     = ROWS * COLS;
  localparam int CIW   = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int DIV_W = $clog2(SCAN_DIV + 2);
  localparam int MW    = 4;

  logic [ROWS-1:0]  r_row_meta, r_row_sync;
  logic [COLS-1:0]  r_col;
  logic             r_run;
  logic [DIV_W-1:0] r_div;
  logic [CIW-1:0]   r_col_idx;
  logic [N-1:0]     r_raw, r_last, r_key, r_pend;
  logic [MW-1:0]    r_match;
  logic             r_multi, r_ovf;

  logic             w_tc, w_fend, w_commit, w_emit, w_pop, w_drop;
  logic [N-1:0]     w_frame;
  logic [MW-1:0]    w_match;
  logic [CODE_W-1:0] w_idx;
  key_evt_t         w_evt, w_head;
  logic             w_full, w_empty;
  logic [$clog2(FIFO_DEPTH):0] w_cnt;

  assign w_tc   = r_run && (r_div == DIV_W'(SCAN_DIV));
  assign w_fend = w_tc && (r_col_idx == CIW'(COLS - 1));

  // Frame as it will look once the current column is captured
  always_comb begin
    w_frame = r_raw;
    w_frame[int'(r_col_idx)*ROWS +: ROWS] = ~r_row_sync;
    if (w_frame == r_last)
      w_match = (r_match == MW'(DEBOUNCE)) ? r_match : r_match + 1'b1;
    else
      w_match = MW'(1);
  end

  assign w_commit = w_fend && (w_match >= MW'(DEBOUNCE)) &&
                    (w_frame != r_key) && (r_pend == '0);

  // Lowest set pending bit goes out first
  always_comb begin
    w_idx = '0;
    for (int i = N - 1; i >= 0; i--)
      if (r_pend[i]) w_idx = CODE_W'(i);
  end

  assign w_emit      = |r_pend;
  assign w_evt.code  = MAX_CODE_W'(w_idx);
  assign w_evt.press = r_key[w_idx];
  assign w_pop       = evt_valid && evt_ready;
  assign w_drop      = w_emit && w_full && !w_pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_row_meta <= '1;
      r_row_sync <= '1;
      r_col      <= '1;
      r_run      <= 1'b0;
      r_div      <= '0;
      r_col_idx  <= '0;
      r_raw      <= '0;
      r_last     <= '0;
      r_key      <= '0;
      r_pend     <= '0;
      r_match    <= '0;
      r_multi    <= 1'b0;
      r_ovf      <= 1'b0;
    end else begin
      r_row_meta <= row;
      r_row_sync <= r_row_meta;
      // First cycle out of reset starts driving column 0
      if (!r_run) begin
        r_run     <= 1'b1;
        r_col     <= {{(COLS-1){1'b1}}, 1'b0};
        r_div     <= '0;
        r_col_idx <= '0;
      end else if (w_tc) begin
        r_div     <= '0;
        r_col     <= {r_col[COLS-2:0], r_col[COLS-1]};
        r_col_idx <= (r_col_idx == CIW'(COLS - 1)) ? '0 : r_col_idx + 1'b1;
        r_raw     <= w_frame;
      end else begin
        r_div <= r_div + 1'b1;
      end
      if (w_fend) begin
        r_match <= w_match;
        r_last  <= w_frame;
      end
      // Commit only with pending empty, so the two branches never collide
      if (w_commit) begin
        r_pend <= w_frame ^ r_key;
        r_key  <= w_frame;
      end else if (w_emit) begin
        r_pend[w_idx] <= 1'b0;
      end
      r_multi <= (r_key & (r_key - N'(1))) != '0;
      if (w_drop)       r_ovf <= 1'b1;
      else if (ovf_clr) r_ovf <= 1'b0;
    end
  end

  keypad_evt_fifo #(.W($bits(key_evt_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_emit),
    .i_din   (w_evt),
    .i_pop   (w_pop),
    .o_dout  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_cnt)
  );

  // Occupancy never exceeds depth and stored codes fit in CODE_W bits
  always_ff @(posedge clk) begin
    if (!rst)
      assert (int'(w_cnt) <= FIFO_DEPTH && (w_head.code >> CODE_W) == '0);
  end

  assign col       = r_col;
  assign evt_valid = !w_empty;
  assign evt_code  = evt_valid ? w_head.code[CODE_W-1:0] : '0;
  assign evt_press = evt_valid & w_head.press;
  assign key_state = r_key;
  assign multi_key = r_multi;
  assign overflow  = r_ovf;

endmodule

// File: doc/keypad_scan_ctrl.md
Name: keypad_scan_ctrl

Overview:
- Parametrised ROWS x COLS matrix-keypad scanner; successor to the fixed 4x4 calculator keypad scanner.
- Adds row synchronisation, frame-level debounce, press and release events, multi-key detection, and a valid/ready event FIFO.
- Sits between the board keypad pins and the calculator control FSM.
- Key-index-to-digit translation lives in the shared package, not in this block.

Parameters:
- ROWS, 4, number of row inputs (2..8)
- COLS, 4, number of column drive outputs (2..8)
- SCAN_DIV, 999999, column dwell in clk cycles minus 1 (dwell = SCAN_DIV+1)
- DEBOUNCE, 3, consecutive identical scan frames required before a frame is committed (1..15)
- FIFO_DEPTH, 4, event FIFO entries (power of 2, >=2)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- row  in  ROWS  raw row lines, active-low, asynchronous
- col  out  COLS  column drive, one-hot active-low
- evt_valid  out  1  FIFO head holds an event
- evt_ready  in  1  consumer accepts head this cycle
- evt_code  out  CODE_W  key index = col_idx*ROWS + row_idx; CODE_W = $clog2(ROWS*COLS)
- evt_press  out  1  1 = press, 0 = release
- key_state  out  ROWS*COLS  debounced stable key map, 1 = pressed
- multi_key  out  1  more than one bit of key_state set
- overflow  out  1  sticky; an event was dropped
- ovf_clr  in  1  synchronous clear of overflow

Behaviour:
- Reset (async, active-high; clock and reset as decided above):
  - col = all ones; evt_valid = 0; evt_code = 0; evt_press = 0; key_state = 0; multi_key = 0; overflow = 0.
  - FIFO emptied; counters, raw frame and pending vector cleared.
  - Reset mid-frame or mid-emission discards all partial state.
- Scan:
  - First cycle after reset release: col = ...1110 (column 0).
  - Dwell counter counts 0..SCAN_DIV. At terminal count:
    - capture ~row_sync into raw[col_idx*ROWS +: ROWS];
    - rotate col left by one; col_idx wraps COLS-1 -> 0.
  - row passes a 2-flop synchroniser (row_sync) before capture.
  - Frame = COLS*(SCAN_DIV+1) cycles. Frame end = capture of column COLS-1.
- Debounce (evaluated at frame end):
  - If raw == last_frame: match_cnt increments, saturating at DEBOUNCE. Otherwise match_cnt = 1.
  - last_frame <= raw.
  - Commit condition: match_cnt >= DEBOUNCE, raw != key_state, and pending == 0. If pending != 0, commit defers to the next frame end.
  - On commit: pending <= raw ^ key_state; key_state <= raw, same cycle.
  - multi_key is registered from key_state (1 cycle after key_state changes).
- Emission:
  - Each cycle pending != 0: select lowest set bit i, push {i, key_state[i]}, clear bit i.
  - Emission is one event per cycle and never stalls.
  - Push accepted if FIFO count < FIFO_DEPTH or a pop occurs the same cycle.
  - Otherwise the event is dropped and overflow <= 1.
- FIFO:
  - Show-ahead: evt_code and evt_press are valid whenever evt_valid = 1.
  - Pop on evt_valid & evt_ready. Head is stable while evt_valid & !evt_ready.
  - Push to an empty FIFO appears on evt_valid the next cycle.
- Overflow:
  - ovf_clr clears overflow.
  - Same-cycle set and clear: set wins.
- Latency: a change stable from frame start reaches evt_valid DEBOUNCE frames + 2 cycles after that frame's end, plus k cycles for its k-th position in pending.

Decomposition:
- Shared package keypad_pkg contains:
  - function key_code_w(rows, cols);
  - CALC_KEYMAP constant for 4x4: index 0..15 -> D,C,B,A,F,9,6,3,0,8,5,2,E,7,4,1;
  - event struct {code, press}.
- One sub-module, keypad_evt_fifo: parametrised synchronous FIFO with push, pop, full, empty, count.

Test Plan:
- All tests use SCAN_DIV=3, DEBOUNCE=2, ROWS=COLS=4, FIFO_DEPTH=4, evt_ready=1 unless stated. Frame = 16 cycles.
- Reset release -> col sequence 1110, 1101, 1011, 0111, 1110, each held 4 cycles; all outputs 0.
- Hold row=1101 while col=1101 (key 5), steady -> exactly one event {code 5, press 1}; key_state = 0x0020. Release -> one event {5, 0}; key_state = 0.
- Bounce: key 5 toggles every frame for 5 frames, then steady -> no events during bounce; a single press event after 2 identical frames.
- Keys 0, 5, 15 pressed in the same frame -> events 0, 5, 15 (press) on consecutive cycles; multi_key = 1. Releasing two keys -> multi_key = 0.
- evt_ready=0, 6 distinct press changes -> FIFO holds first 4; overflow = 1. ovf_clr pulse -> overflow = 0; head still code of first event.
- Assert rst mid-emission with 2 events pending -> FIFO empty, key_state = 0, col = 1111, no stale events after release.
